// File: rtl/spi_frame_receiver_if.sv
// Serial frame link bundle between a chip-select framed sender and its receiver.
// Latency: none (wires only).
// Backpressure: out_ready/out_valid handshake on the parallel side; the serial side has none.
// Ports:
//   cs, sdi            - frame enable and MSB-first serial data (sender -> receiver)
//   out_ready          - downstream accepts out_data this cycle (consumer -> receiver)
//   out_data/out_valid - completed word and its valid flag (receiver -> consumer)
//   frame_err, overrun - single-cycle status pulses (receiver -> consumer)
//   busy               - frame in progress (receiver -> consumer)
interface spi_frame_receiver_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  cs;
  logic                  sdi;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  frame_err;
  logic                  overrun;
  logic                  busy;

  // master: the side that drives the serial link and consumes words
  modport master (
    output cs, sdi, out_ready,
    input  out_data, out_valid, frame_err, overrun, busy
  );

  // slave: the deserializer itself
  modport slave (
    input  cs, sdi, out_ready,
    output out_data, out_valid, frame_err, overrun, busy
  );
endinterface

// File: rtl/spi_frame_receiver.sv
// Chip-select framed serial deserializer: drops LEAD_BITS, shifts in a DATA_WIDTH word MSB-first.
// Latency: out_valid rises on the edge sampling the last payload bit (LEAD_BITS+DATA_WIDTH edges from start).
// Backpressure: one-deep output register; a word completing while the register is full and
//   out_ready is low is dropped and reported with a one-cycle overrun pulse.
// Ports:
//   clk  - rising-edge clock, one serial bit per cycle while cs is high
//   rst  - asynchronous active-high reset
//   bus  - slave side of spi_frame_receiver_if (cs, sdi, out_ready in; out_data, out_valid,
//          frame_err, overrun, busy out). The interface DATA_WIDTH must match this module's.
// DATA_WIDTH >= 2 is assumed; 2**CNT_WIDTH must exceed LEAD_BITS + DATA_WIDTH.
module spi_frame_receiver #(
  parameter int DATA_WIDTH = 16,
  parameter int LEAD_BITS  = 0,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                clk,
  input  logic                rst,
  spi_frame_receiver_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SKIP  = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Bit index of the last discarded bit and of the last payload bit.
  localparam logic [CNT_WIDTH-1:0] SKIP_LAST = CNT_WIDTH'(LEAD_BITS - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_IDX  = CNT_WIDTH'(LEAD_BITS + DATA_WIDTH - 1);

  state_t                state;
  logic                  cs_q;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_valid_q;
  logic                  frame_err_q;
  logic                  overrun_q;
  logic                  busy_q;

  logic                  start;
  logic [DATA_WIDTH-1:0] word;

  // cs_q resets high so a frame already running at reset release is not mistaken for a start.
  assign start = bus.cs & ~cs_q;
  // Shift register with the current bit appended: the finished word on the completing edge.
  assign word  = (shreg << 1) | DATA_WIDTH'(bus.sdi);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cs_q        <= 1'b1;
      cnt         <= '0;
      shreg       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cs_q        <= bus.cs;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      // Consumption; a load on the same edge below takes priority and keeps out_valid set.
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          cnt <= '0;
          if (start) begin
            // The start edge already consumes bit index 0.
            cnt    <= CNT_WIDTH'(1);
            busy_q <= 1'b1;
            if (LEAD_BITS == 0) begin
              shreg <= DATA_WIDTH'(bus.sdi);
              state <= SHIFT;
            end else if (LEAD_BITS == 1) begin
              // The single lead bit was the start bit itself; nothing left to skip.
              state <= SHIFT;
            end else begin
              state <= SKIP;
            end
          end
        end

        SKIP: begin
          if (!bus.cs) begin
            frame_err_q <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
            if (cnt == SKIP_LAST) begin
              state <= SHIFT;
            end
          end
        end

        SHIFT: begin
          if (!bus.cs) begin
            frame_err_q <= 1'b1;
            busy_q      <= 1'b0;
            shreg       <= '0;
            state       <= IDLE;
          end else begin
            shreg <= word;
            cnt   <= cnt + CNT_WIDTH'(1);
            if (cnt == LAST_IDX) begin
              state <= HOLD;
              if (!out_valid_q || bus.out_ready) begin
                out_data_q  <= word;
                out_valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end
          end
        end

        HOLD: begin
          // Counter is frozen here, so an over-long cs never wraps it.
          if (!bus.cs) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end

        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = busy_q;

endmodule
